// File: rtl/lane_arrival_queue_if.sv
// Bus bundle for lane_arrival_queue: LFSR word in, green map in, queue state and pulses out.
// The o_Peak_Len signal exists only when LANE_QUEUE_PEAK_EN is defined.
interface lane_arrival_queue_if #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_LANES = 4,
  parameter int QUEUE_W   = 4
);
  logic                         i_Enable;
  logic [NUM_BITS-1:0]          i_LFSR_Data;
  logic [NUM_BITS-1:0]          i_Arrival_Thresh;
  logic [NUM_LANES-1:0]         i_Green;
  logic                         o_LFSR_Enable;
  logic                         o_Tick;
  logic [NUM_LANES-1:0]         o_Arrival;
  logic [NUM_LANES-1:0]         o_Depart;
  logic [NUM_LANES*QUEUE_W-1:0] o_Queue_Len;
  logic [NUM_LANES-1:0]         o_Overflow;
`ifdef LANE_QUEUE_PEAK_EN
  logic [NUM_LANES*QUEUE_W-1:0] o_Peak_Len;
`endif

  modport master (
    output i_Enable, i_LFSR_Data, i_Arrival_Thresh, i_Green,
    input  o_LFSR_Enable, o_Tick, o_Arrival, o_Depart, o_Queue_Len, o_Overflow
`ifdef LANE_QUEUE_PEAK_EN
    , input o_Peak_Len
`endif
  );

  modport slave (
    input  i_Enable, i_LFSR_Data, i_Arrival_Thresh, i_Green,
    output o_LFSR_Enable, o_Tick, o_Arrival, o_Depart, o_Queue_Len, o_Overflow
`ifdef LANE_QUEUE_PEAK_EN
    , output o_Peak_Len
`endif
  );
endinterface

// File: rtl/lane_arrival_queue.sv
// Per-lane arrival queues fed by an LFSR word sampled once per tick; green lanes discharge.
// Optional LANE_QUEUE_PEAK_EN adds o_Peak_Len, the per-lane maximum queue length since reset.
module lane_arrival_queue #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_LANES = 4,
  parameter int QUEUE_W   = 4,
  parameter int TICK_DIV  = 1000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  lane_arrival_queue_if.slave bus
);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ROT_STEP = NUM_BITS / NUM_LANES;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [QUEUE_W-1:0] Q_MAX    = {QUEUE_W{1'b1}};
  localparam logic [QUEUE_W-1:0] Q_ONE    = QUEUE_W'(1);

  function automatic logic [NUM_BITS-1:0] rotl(input logic [NUM_BITS-1:0] w, input int sh);
    return (w << sh) | (w >> (NUM_BITS - sh));
  endfunction

  logic [CNT_W-1:0]   cnt_r;
  logic               tick_r;
  logic [NUM_LANES-1:0] arrival_r, depart_r, overflow_r;
  logic [QUEUE_W-1:0] queue_r [NUM_LANES];

  logic               sample_s;
  logic [NUM_BITS-1:0] rot_s [NUM_LANES];
  logic [NUM_LANES-1:0] arrival_s, depart_s, overflow_nxt_s;
  logic [QUEUE_W-1:0] queue_nxt_s [NUM_LANES];

  assign sample_s          = bus.i_Enable && (cnt_r == CNT_LAST);
  assign bus.o_LFSR_Enable = sample_s;

  // Sample-tick divider; holds its phase while disabled.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_r <= '0;
    end else if (bus.i_Enable) begin
      if (cnt_r == CNT_LAST) cnt_r <= '0;
      else                   cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Arrival decision and next queue value per lane; departures see the pre-update length.
  always_comb begin
    arrival_s      = '0;
    depart_s       = '0;
    overflow_nxt_s = overflow_r;
    for (int k = 0; k < NUM_LANES; k++) begin
      rot_s[k]       = rotl(bus.i_LFSR_Data, k * ROT_STEP);
      queue_nxt_s[k] = queue_r[k];
      arrival_s[k]   = rot_s[k] < bus.i_Arrival_Thresh;
      depart_s[k]    = bus.i_Green[k] && (queue_r[k] != '0);
      case ({arrival_s[k], depart_s[k]})
        2'b10: begin
          if (queue_r[k] == Q_MAX) overflow_nxt_s[k] = 1'b1;
          else                     queue_nxt_s[k]    = queue_r[k] + Q_ONE;
        end
        2'b01:   queue_nxt_s[k] = queue_r[k] - Q_ONE;
        default: queue_nxt_s[k] = queue_r[k];
      endcase
    end
  end

  // Queue state and sticky overflow change only on the sampling edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      overflow_r <= '0;
      for (int k = 0; k < NUM_LANES; k++) queue_r[k] <= '0;
    end else if (sample_s) begin
      overflow_r <= overflow_nxt_s;
      for (int k = 0; k < NUM_LANES; k++) queue_r[k] <= queue_nxt_s[k];
    end
  end

  // One-cycle pulses aligned with the updated queue lengths.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tick_r    <= 1'b0;
      arrival_r <= '0;
      depart_r  <= '0;
    end else begin
      tick_r    <= sample_s;
      arrival_r <= sample_s ? arrival_s : '0;
      depart_r  <= sample_s ? depart_s  : '0;
    end
  end

  assign bus.o_Tick     = tick_r;
  assign bus.o_Arrival  = arrival_r;
  assign bus.o_Depart   = depart_r;
  assign bus.o_Overflow = overflow_r;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
    assign bus.o_Queue_Len[g*QUEUE_W +: QUEUE_W] = queue_r[g];
  end

`ifdef LANE_QUEUE_PEAK_EN
  logic [QUEUE_W-1:0] peak_r [NUM_LANES];

  // Running per-lane maximum, tracked against the value being written this edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < NUM_LANES; k++) peak_r[k] <= '0;
    end else if (sample_s) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (queue_nxt_s[k] > peak_r[k]) peak_r[k] <= queue_nxt_s[k];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_peak
    assign bus.o_Peak_Len[g*QUEUE_W +: QUEUE_W] = peak_r[g];
  end
`endif
endmodule
